// File: rtl/drive_cmd_pkg.sv
// Shared types, output encodings and remote/UART decode helpers for the
// drive command arbiter.
package drive_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_BLOCKED = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_FWD   = 3'd1,
        CMD_LEFT  = 3'd2,
        CMD_BRAKE = 3'd3,
        CMD_RIGHT = 3'd4,
        CMD_BACK  = 3'd5
    } cmd_e;

    localparam logic [7:0] SEND_NONE  = 8'h00;
    localparam logic [7:0] SEND_FWD   = 8'h02;
    localparam logic [7:0] SEND_LEFT  = 8'h08;
    localparam logic [7:0] SEND_BRAKE = 8'h10;
    localparam logic [7:0] SEND_RIGHT = 8'h20;
    localparam logic [7:0] SEND_BACK  = 8'h80;

    localparam logic [2:0] STAT_IDLE  = 3'b000;
    localparam logic [2:0] STAT_FWD   = 3'b001;
    localparam logic [2:0] STAT_LEFT  = 3'b010;
    localparam logic [2:0] STAT_BRAKE = 3'b011;
    localparam logic [2:0] STAT_RIGHT = 3'b100;
    localparam logic [2:0] STAT_BACK  = 3'b101;

    localparam logic [7:0] DUTY_MAX = 8'd100;

    function automatic cmd_e ir_decode(input logic [3:0] digit);
        cmd_e c;
        case (digit)
            4'd2:    c = CMD_FWD;
            4'd4:    c = CMD_LEFT;
            4'd5:    c = CMD_BRAKE;
            4'd6:    c = CMD_RIGHT;
            4'd8:    c = CMD_BACK;
            default: c = CMD_NONE;
        endcase
        return c;
    endfunction

    function automatic cmd_e uart_decode(input logic [7:0] code);
        cmd_e c;
        case (code)
            8'h61:   c = CMD_FWD;
            8'h62:   c = CMD_LEFT;
            8'h63:   c = CMD_BRAKE;
            8'h64:   c = CMD_RIGHT;
            8'h65:   c = CMD_BACK;
            default: c = CMD_NONE;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] cmd_send(input cmd_e c);
        logic [7:0] s;
        case (c)
            CMD_FWD:   s = SEND_FWD;
            CMD_LEFT:  s = SEND_LEFT;
            CMD_BRAKE: s = SEND_BRAKE;
            CMD_RIGHT: s = SEND_RIGHT;
            CMD_BACK:  s = SEND_BACK;
            default:   s = SEND_NONE;
        endcase
        return s;
    endfunction

    function automatic logic [2:0] cmd_stat(input cmd_e c);
        logic [2:0] s;
        case (c)
            CMD_FWD:   s = STAT_FWD;
            CMD_LEFT:  s = STAT_LEFT;
            CMD_BRAKE: s = STAT_BRAKE;
            CMD_RIGHT: s = STAT_RIGHT;
            CMD_BACK:  s = STAT_BACK;
            default:   s = STAT_IDLE;
        endcase
        return s;
    endfunction

    // Brake and none carry no direction, so they never count as a reversal.
    function automatic logic cmd_is_moving(input cmd_e c);
        return (c == CMD_FWD) || (c == CMD_LEFT) || (c == CMD_RIGHT) || (c == CMD_BACK);
    endfunction

    function automatic logic [7:0] clamp_pct(input int pct);
        logic [7:0] r;
        if (pct <= 0)
            r = 8'd0;
        else if (pct >= 100)
            r = DUTY_MAX;
        else
            r = 8'(pct);
        return r;
    endfunction

endpackage

// File: rtl/drive_cmd_arbiter_duty_ramp.sv
// Duty target selection plus slew-limited ramp: drops apply at once, rises
// advance by at most RAMP_STEP every RAMP_DIV cycles.
module duty_ramp
    import drive_cmd_pkg::*;
#(
    parameter int PROX_W      = 4,
    parameter int NEAR_THRESH = 8,
    parameter int FAST_DUTY   = 60,
    parameter int SLOW_DUTY   = 40,
    parameter int RAMP_DIV    = 1000,
    parameter int RAMP_STEP   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  state_e            state_nxt,
    input  cmd_e              cmd_nxt,
    input  logic [PROX_W-1:0] prox_dist,
    input  logic              force_zero,
    output logic [6:0]        duty
);

    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [PROX_W-1:0] NEAR_T =
        (NEAR_THRESH >= (1 << PROX_W)) ? {PROX_W{1'b1}} : PROX_W'(NEAR_THRESH);
    localparam logic [7:0] FAST8 = clamp_pct(FAST_DUTY);
    localparam logic [7:0] SLOW8 = clamp_pct(SLOW_DUTY);
    localparam logic [7:0] STEP8 = clamp_pct(RAMP_STEP);

    logic [7:0]       tgt_d, tgt_q;
    logic [6:0]       duty_d, duty_q;
    logic [DIV_W-1:0] div_d, div_q;
    logic [7:0]       duty_ext, gap, inc, sum;

    // Target follows the state being entered so blocking/idling drops duty on the same edge.
    always_comb begin
        tgt_d = 8'd0;
        if (state_nxt == ST_DRIVE && cmd_is_moving(cmd_nxt))
            tgt_d = (prox_dist <= NEAR_T) ? SLOW8 : FAST8;
    end

    always_comb begin
        duty_ext = {1'b0, duty_q};
        gap      = tgt_q - duty_ext;
        inc      = (gap < STEP8) ? gap : STEP8;
        sum      = duty_ext + inc;
        duty_d   = duty_q;
        div_d    = div_q;
        if (force_zero) begin
            duty_d = 7'd0;
            div_d  = '0;
        end else if (tgt_d != tgt_q) begin
            div_d = '0;
            if (duty_ext > tgt_d)
                duty_d = tgt_d[6:0];
        end else if (duty_ext > tgt_q) begin
            duty_d = tgt_q[6:0];
            div_d  = '0;
        end else if (duty_ext < tgt_q) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                duty_d = sum[7] ? 7'd100 : sum[6:0];
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end else begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q  <= 8'd0;
            duty_q <= 7'd0;
            div_q  <= '0;
        end else begin
            tgt_q  <= tgt_d;
            duty_q <= duty_d;
            div_q  <= div_d;
        end
    end

    assign duty = duty_q;

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Top-level drive command arbiter: IR/UART strobe arbitration, dead-man
// watchdog, forward obstacle interlock and ramped motor duty.
module drive_cmd_arbiter
    import drive_cmd_pkg::*;
#(
    parameter int PROX_W      = 4,
    parameter int STOP_THRESH = 2,
    parameter int NEAR_THRESH = 8,
    parameter int FAST_DUTY   = 60,
    parameter int SLOW_DUTY   = 40,
    parameter int RAMP_DIV    = 1000,
    parameter int RAMP_STEP   = 5,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IR_VALID,
    input  logic [3:0]        IR_DIGIT,
    input  logic              UART_VALID,
    input  logic [7:0]        UART_BYTE,
    input  logic [PROX_W-1:0] PROX_DIST,
    output logic [7:0]        SEND,
    output logic [2:0]        MOTOR_STAT,
    output logic [6:0]        DUTY,
    output logic              CMD_SRC,
    output logic              BAD_CMD,
    output logic              BLOCKED
);

    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [PROX_W-1:0] STOP_T =
        (STOP_THRESH >= (1 << PROX_W)) ? {PROX_W{1'b1}} : PROX_W'(STOP_THRESH);

    logic            rst_meta_q, rst_sync_q;
    state_e          state_d, state_q;
    cmd_e            cmd_d, cmd_q;
    logic            src_d, src_q;
    logic            bad_d, bad_q;
    logic [WD_W-1:0] wd_d, wd_q;
    logic            dir_chg;
    cmd_e            strobe_cmd;
    logic            strobe_src, strobe_ok, strobe_bad;
    logic            prox_stop, wd_exp;

    // Reset asserts immediately but is released on a clock edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // IR wins a same-cycle collision; the UART strobe is simply dropped.
    always_comb begin
        strobe_cmd = IR_VALID ? ir_decode(IR_DIGIT) : uart_decode(UART_BYTE);
        strobe_src = ~IR_VALID;
        strobe_ok  = (IR_VALID | UART_VALID) && (strobe_cmd != CMD_NONE);
        strobe_bad = (IR_VALID | UART_VALID) && (strobe_cmd == CMD_NONE);
    end

    assign prox_stop = (PROX_DIST <= STOP_T);
    assign wd_exp    = (wd_q == WD_LAST);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        src_d   = src_q;
        bad_d   = strobe_bad;
        wd_d    = wd_q;
        dir_chg = 1'b0;
        if (strobe_ok)
            src_d = strobe_src;
        unique case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (strobe_ok) begin
                    state_d = ST_DRIVE;
                    cmd_d   = strobe_cmd;
                end
            end
            ST_DRIVE: begin
                if (strobe_ok) begin
                    cmd_d   = strobe_cmd;
                    wd_d    = '0;
                    dir_chg = cmd_is_moving(cmd_q) && cmd_is_moving(strobe_cmd)
                              && (strobe_cmd != cmd_q);
                end else if (wd_exp) begin
                    state_d = ST_IDLE;
                    cmd_d   = CMD_NONE;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (cmd_q == CMD_FWD && prox_stop)
                        state_d = ST_BLOCKED;
                end
            end
            ST_BLOCKED: begin
                // Only a fresh command releases the interlock; clearance alone does not.
                if (strobe_ok) begin
                    cmd_d = strobe_cmd;
                    wd_d  = '0;
                    if (strobe_cmd != CMD_FWD || !prox_stop)
                        state_d = ST_DRIVE;
                end else if (wd_exp) begin
                    state_d = ST_IDLE;
                    cmd_d   = CMD_NONE;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cmd_d   = CMD_NONE;
                wd_d    = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NONE;
            src_q   <= 1'b0;
            bad_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            src_q   <= src_d;
            bad_q   <= bad_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        SEND       = SEND_NONE;
        MOTOR_STAT = STAT_IDLE;
        BLOCKED    = 1'b0;
        unique case (state_q)
            ST_DRIVE: begin
                SEND       = cmd_send(cmd_q);
                MOTOR_STAT = cmd_stat(cmd_q);
            end
            ST_BLOCKED: begin
                SEND       = SEND_BRAKE;
                MOTOR_STAT = STAT_BRAKE;
                BLOCKED    = 1'b1;
            end
            default: ;
        endcase
    end

    assign CMD_SRC = src_q;
    assign BAD_CMD = bad_q;

    duty_ramp #(
        .PROX_W      (PROX_W),
        .NEAR_THRESH (NEAR_THRESH),
        .FAST_DUTY   (FAST_DUTY),
        .SLOW_DUTY   (SLOW_DUTY),
        .RAMP_DIV    (RAMP_DIV),
        .RAMP_STEP   (RAMP_STEP)
    ) u_duty_ramp (
        .clk        (CLK),
        .rst_n      (rst_sync_q),
        .state_nxt  (state_d),
        .cmd_nxt    (cmd_d),
        .prox_dist  (PROX_DIST),
        .force_zero (dir_chg),
        .duty       (DUTY)
    );

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Self-checking bench for drive_cmd_arbiter: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_drive_cmd_arbiter;

    localparam int PROX_W      = 4;
    localparam int STOP_THRESH = 2;
    localparam int NEAR_THRESH = 8;
    localparam int FAST_DUTY   = 60;
    localparam int SLOW_DUTY   = 40;
    localparam int RAMP_DIV    = 4;
    localparam int RAMP_STEP   = 5;
    localparam int TIMEOUT_CYC = 20;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              IR_VALID = 1'b0;
    logic [3:0]        IR_DIGIT = 4'd0;
    logic              UART_VALID = 1'b0;
    logic [7:0]        UART_BYTE = 8'd0;
    logic [PROX_W-1:0] PROX_DIST = 4'd15;
    logic [7:0]        SEND;
    logic [2:0]        MOTOR_STAT;
    logic [6:0]        DUTY;
    logic              CMD_SRC, BAD_CMD, BLOCKED;
    logic [20:0]       dut_vec;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: mode 0 idle / 1 drive / 2 blocked, cmd = motor status code.
    int m_mode = 0, m_cmd = 0, m_src = 0, m_bad = 0, m_age = 0;
    int m_duty = 0, m_prev_tgt = 0, m_phase = 0;

    drive_cmd_arbiter #(
        .PROX_W(PROX_W), .STOP_THRESH(STOP_THRESH), .NEAR_THRESH(NEAR_THRESH),
        .FAST_DUTY(FAST_DUTY), .SLOW_DUTY(SLOW_DUTY), .RAMP_DIV(RAMP_DIV),
        .RAMP_STEP(RAMP_STEP), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .IR_VALID(IR_VALID), .IR_DIGIT(IR_DIGIT),
        .UART_VALID(UART_VALID), .UART_BYTE(UART_BYTE), .PROX_DIST(PROX_DIST),
        .SEND(SEND), .MOTOR_STAT(MOTOR_STAT), .DUTY(DUTY), .CMD_SRC(CMD_SRC),
        .BAD_CMD(BAD_CMD), .BLOCKED(BLOCKED)
    );

    assign dut_vec = {SEND, MOTOR_STAT, DUTY, CMD_SRC, BAD_CMD, BLOCKED};

    always #5 CLK = ~CLK;

    function automatic int ir_code(int d);
        case (d)
            2: return 1;
            4: return 2;
            5: return 3;
            6: return 4;
            8: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int uart_code(int b);
        return (b >= 'h61 && b <= 'h65) ? b - 'h60 : 0;
    endfunction

    function automatic int onehot_of(int c);
        case (c)
            1: return 'h02;
            2: return 'h08;
            3: return 'h10;
            4: return 'h20;
            5: return 'h80;
            default: return 0;
        endcase
    endfunction

    function automatic bit moving(int c);
        return (c == 1) || (c == 2) || (c == 4) || (c == 5);
    endfunction

    function automatic logic [20:0] model_vec();
        int s, st;
        s  = (m_mode == 0) ? 0 : (m_mode == 2) ? 'h10 : onehot_of(m_cmd);
        st = (m_mode == 0) ? 0 : (m_mode == 2) ? 3 : m_cmd;
        return {8'(s), 3'(st), 7'(m_duty), 1'(m_src), 1'(m_bad), 1'(m_mode == 2)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cmd = 0; m_src = 0; m_bad = 0; m_age = 0;
        m_duty = 0; m_prev_tgt = 0; m_phase = 0;
    endtask

    task automatic model_step();
        int c, p, nmode, ncmd, tgt, room;
        bit v, acc, dz;
        p     = int'(PROX_DIST);
        v     = IR_VALID || UART_VALID;
        c     = IR_VALID ? ir_code(int'(IR_DIGIT)) : uart_code(int'(UART_BYTE));
        acc   = v && (c != 0);
        m_bad = (v && (c == 0)) ? 1 : 0;
        if (acc) m_src = IR_VALID ? 0 : 1;
        nmode = m_mode; ncmd = m_cmd; dz = 0;
        if (m_mode == 0) begin
            m_age = 0;
            if (acc) begin nmode = 1; ncmd = c; end
        end else if (acc) begin
            m_age = 0;
            ncmd  = c;
            if (m_mode == 1) dz = moving(m_cmd) && moving(c) && (c != m_cmd);
            else if (c != 1 || p > STOP_THRESH) nmode = 1;
        end else if (m_age == TIMEOUT_CYC - 1) begin
            nmode = 0; ncmd = 0; m_age = 0;
        end else begin
            m_age++;
            if (m_mode == 1 && m_cmd == 1 && p <= STOP_THRESH) nmode = 2;
        end
        tgt = (nmode == 1 && moving(ncmd)) ? ((p <= NEAR_THRESH) ? SLOW_DUTY : FAST_DUTY) : 0;
        if (dz) begin
            m_duty = 0; m_phase = 0;
        end else if (tgt != m_prev_tgt) begin
            m_phase = 0;
            if (m_duty > tgt) m_duty = tgt;
        end else if (m_duty < tgt) begin
            m_phase++;
            if (m_phase == RAMP_DIV) begin
                room    = tgt - m_duty;
                m_duty += (room < RAMP_STEP) ? room : RAMP_STEP;
                m_phase = 0;
            end
        end else begin
            m_phase = 0;
        end
        m_prev_tgt = tgt; m_mode = nmode; m_cmd = ncmd;
    endtask

    task automatic cyc();
        @(posedge CLK);
        if (!RST_N) model_reset();
        else model_step();
        #1;
    endtask

    task automatic uart_strobe(input logic [7:0] b);
        UART_VALID = 1'b1; UART_BYTE = b;
        cyc();
        UART_VALID = 1'b0;
    endtask

    task automatic ir_strobe(input logic [3:0] d);
        IR_VALID = 1'b1; IR_DIGIT = d;
        cyc();
        IR_VALID = 1'b0;
    endtask

    task automatic apply_reset();
        IR_VALID = 1'b0; UART_VALID = 1'b0;
        #2 RST_N = 1'b0;
        #1 model_reset();
        repeat (2) cyc();
        RST_N = 1'b1;
        repeat (3) cyc();
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (dut_vec !== 21'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want %h", dut_vec, 21'd0);
        end
    endtask

    task automatic test_uart_fwd_ramp();
        int want;
        apply_reset();
        PROX_DIST = 4'd15;
        uart_strobe(8'h61);
        n_cmp++;
        if (SEND !== 8'h02 || MOTOR_STAT !== 3'b001 || CMD_SRC !== 1'b1 || DUTY !== 7'd0) begin
            n_fail++;
            $display("FAIL fwd_first: got send=%h stat=%b src=%b duty=%0d want 02/001/1/0",
                     SEND, MOTOR_STAT, CMD_SRC, DUTY);
        end
        for (int j = 1; j <= 64; j++) begin
            if (j % 10 == 0) uart_strobe(8'h61);
            else cyc();
            want = (j / RAMP_DIV) * RAMP_STEP;
            if (want > FAST_DUTY) want = FAST_DUTY;
            n_cmp++;
            if (DUTY !== 7'(want) || SEND !== 8'h02) begin
                n_fail++;
                $display("FAIL ramp_j%0d: got duty=%0d send=%h want duty=%0d send=02",
                         j, DUTY, SEND, want);
            end
        end
    endtask

    task automatic test_reset_mid_ramp();
        int j;
        apply_reset();
        PROX_DIST = 4'd15;
        uart_strobe(8'h61);
        j = 0;
        while (DUTY !== 7'd35 && j < 100) begin
            j++;
            if (j % 10 == 0) uart_strobe(8'h61);
            else cyc();
        end
        n_cmp++;
        if (DUTY !== 7'd35) begin
            n_fail++; $display("FAIL reach_35: got %0d want 35", DUTY);
        end
        #2 RST_N = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec !== 21'd0) begin
            n_fail++; $display("FAIL async_reset: got %h want %h", dut_vec, 21'd0);
        end
        model_reset();
        repeat (2) cyc();
        RST_N = 1'b1;
        repeat (3) cyc();
        n_cmp++;
        if (dut_vec !== 21'd0) begin
            n_fail++; $display("FAIL post_reset_idle: got %h want %h", dut_vec, 21'd0);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        IR_VALID = 1'b1; IR_DIGIT = 4'd6;
        UART_VALID = 1'b1; UART_BYTE = 8'h65;
        cyc();
        IR_VALID = 1'b0; UART_VALID = 1'b0;
        n_cmp++;
        if (SEND !== 8'h20 || CMD_SRC !== 1'b0 || MOTOR_STAT !== 3'b100) begin
            n_fail++;
            $display("FAIL collide: got send=%h src=%b stat=%b want 20/0/100", SEND, CMD_SRC, MOTOR_STAT);
        end
        repeat (3) cyc();
        n_cmp++;
        if (SEND !== 8'h20) begin
            n_fail++; $display("FAIL collide_hold: got %h want 20", SEND);
        end
    endtask

    task automatic test_interlock();
        apply_reset();
        PROX_DIST = 4'd15;
        uart_strobe(8'h61);
        repeat (6) cyc();
        PROX_DIST = 4'd2;
        cyc();
        n_cmp++;
        if (SEND !== 8'h10 || BLOCKED !== 1'b1 || DUTY !== 7'd0 || MOTOR_STAT !== 3'b011) begin
            n_fail++;
            $display("FAIL block_enter: got send=%h blk=%b duty=%0d stat=%b want 10/1/0/011",
                     SEND, BLOCKED, DUTY, MOTOR_STAT);
        end
        PROX_DIST = 4'd15;
        repeat (5) cyc();
        n_cmp++;
        if (SEND !== 8'h10 || BLOCKED !== 1'b1) begin
            n_fail++; $display("FAIL block_sticky: got send=%h blk=%b want 10/1", SEND, BLOCKED);
        end
        uart_strobe(8'h61);
        n_cmp++;
        if (SEND !== 8'h02 || BLOCKED !== 1'b0 || MOTOR_STAT !== 3'b001) begin
            n_fail++;
            $display("FAIL block_resume: got send=%h blk=%b stat=%b want 02/0/001", SEND, BLOCKED, MOTOR_STAT);
        end
    endtask

    task automatic test_watchdog();
        apply_reset();
        PROX_DIST = 4'd15;
        uart_strobe(8'h61);
        repeat (TIMEOUT_CYC - 1) cyc();
        n_cmp++;
        if (SEND !== 8'h02) begin
            n_fail++; $display("FAIL wd_before: got %h want 02", SEND);
        end
        cyc();
        n_cmp++;
        if (SEND !== 8'h00 || DUTY !== 7'd0 || MOTOR_STAT !== 3'b000) begin
            n_fail++;
            $display("FAIL wd_expire: got send=%h duty=%0d stat=%b want 00/0/000", SEND, DUTY, MOTOR_STAT);
        end
        uart_strobe(8'h61);
        repeat (TIMEOUT_CYC - 1) cyc();
        uart_strobe(8'h61);
        n_cmp++;
        if (SEND !== 8'h02) begin
            n_fail++; $display("FAIL wd_refresh_edge: got %h want 02", SEND);
        end
        repeat (TIMEOUT_CYC - 1) cyc();
        n_cmp++;
        if (SEND !== 8'h02) begin
            n_fail++; $display("FAIL wd_refresh_hold: got %h want 02", SEND);
        end
        cyc();
        n_cmp++;
        if (SEND !== 8'h00) begin
            n_fail++; $display("FAIL wd_refresh_expire: got %h want 00", SEND);
        end
    endtask

    task automatic test_bad_cmd();
        apply_reset();
        PROX_DIST = 4'd15;
        ir_strobe(4'd2);
        repeat (9) cyc();
        ir_strobe(4'd7);
        n_cmp++;
        if (BAD_CMD !== 1'b1 || SEND !== 8'h02 || CMD_SRC !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_pulse: got bad=%b send=%h src=%b want 1/02/0", BAD_CMD, SEND, CMD_SRC);
        end
        cyc();
        n_cmp++;
        if (BAD_CMD !== 1'b0) begin
            n_fail++; $display("FAIL bad_one_cycle: got %b want 0", BAD_CMD);
        end
        repeat (8) cyc();
        n_cmp++;
        if (SEND !== 8'h02) begin
            n_fail++; $display("FAIL bad_wd_hold: got %h want 02", SEND);
        end
        cyc();
        n_cmp++;
        if (SEND !== 8'h00) begin
            n_fail++; $display("FAIL bad_no_refresh: got %h want 00", SEND);
        end
    endtask

    task automatic test_dir_change();
        apply_reset();
        PROX_DIST = 4'd15;
        uart_strobe(8'h61);
        for (int j = 1; j <= 50; j++) begin
            if (j % 10 == 0) uart_strobe(8'h61);
            else cyc();
        end
        n_cmp++;
        if (DUTY !== 7'd60) begin
            n_fail++; $display("FAIL dir_pre: got %0d want 60", DUTY);
        end
        uart_strobe(8'h65);
        n_cmp++;
        if (DUTY !== 7'd0 || SEND !== 8'h80) begin
            n_fail++; $display("FAIL dir_zero: got duty=%0d send=%h want 0/80", DUTY, SEND);
        end
        repeat (RAMP_DIV) cyc();
        n_cmp++;
        if (DUTY !== 7'd5) begin
            n_fail++; $display("FAIL dir_ramp: got %0d want 5", DUTY);
        end
    endtask

    task automatic test_random();
        logic [3:0] good [5] = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd8};
        logic [20:0] want;
        bit quiet;
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            quiet      = (i % 150) >= 115;
            IR_VALID   = !quiet && ($urandom_range(0, 7) == 0);
            UART_VALID = !quiet && ($urandom_range(0, 5) == 0);
            IR_DIGIT   = ($urandom_range(0, 1) == 1) ? good[$urandom_range(0, 4)]
                                                     : 4'($urandom_range(0, 15));
            UART_BYTE  = ($urandom_range(0, 1) == 1) ? 8'(8'h61 + $urandom_range(0, 4))
                                                     : 8'($urandom);
            if ($urandom_range(0, 19) == 0) PROX_DIST = 4'($urandom_range(0, 15));
            cyc();
            want = model_vec();
            n_cmp++;
            if (dut_vec !== want) begin
                n_fail++;
                $display("FAIL rand_cyc%0d: got %h want %h (send,stat,duty,src,bad,blk)", i, dut_vec, want);
            end
        end
        IR_VALID = 1'b0; UART_VALID = 1'b0;
    endtask

    initial begin
        test_reset();
        test_uart_fwd_ramp();
        test_reset_mid_ramp();
        test_simultaneous();
        test_interlock();
        test_watchdog();
        test_bad_cmd();
        test_dir_change();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish by 500000 ns");
        $fatal(1, "time limit");
    end

endmodule
